plot_arbiter: RTL
=================

Name: plot_arbiter

Overview:
- Downstream of the screen-clear stage and the tile renderer, upstream of the VGA adapter.
- Merges the two pixel-write streams into one plot stream.
- The clear stream has absolute priority and, once started, holds the bus until its last pixel.
- A small FIFO decouples both sources from adapter stalls; the output is registered.

Parameters:
- X_W, 9, x coordinate width
- Y_W, 8, y coordinate width
- COLOUR_W, 3, colour width
- DEPTH, 4, FIFO entries (power of two, ≥2)
- SCREEN_W, 320, visible width (used by the optional feature)
- SCREEN_H, 240, visible height (used by the optional feature)

Ports:
- clock in 1: system clock, rising edge
- resetn in 1: asynchronous active-low reset
- clr_valid in 1: clear-stage pixel valid
- clr_ready out 1: clear-stage pixel accepted
- clr_last in 1: marks the final pixel of a clear pass
- clr_x in X_W, clr_y in Y_W, clr_colour in COLOUR_W: clear-stage pixel
- til_valid in 1: tile pixel valid
- til_ready out 1: tile pixel accepted
- til_x in X_W, til_y in Y_W, til_colour in COLOUR_W: tile pixel
- out_plot out 1: pixel presented to the VGA adapter
- out_ready in 1: adapter accepts (low = stall)
- out_x out X_W, out_y out Y_W, out_colour out COLOUR_W: presented pixel
- clear_active out 1: a clear pass is in progress
- busy out 1: clear_active OR FIFO non-empty

Behaviour:
- Reset (async, any time, including mid-pass): FIFO emptied, lock cleared. out_plot=0, out_x/out_y/out_colour=0, clear_active=0, busy=0. Pixels in flight are discarded.
- lock register:
  - Set on a clr handshake with clr_last=0.
  - Cleared on a clr handshake with clr_last=1.
  - A single-pixel pass (clr_last=1 on its first pixel) never sets lock.
  - clear_active = lock OR clr_valid.
- Grant (combinational):
  - grant_clr = lock OR clr_valid.
  - clr_ready = grant_clr AND NOT full.
  - til_ready = NOT grant_clr AND NOT full.
  - til_ready depends combinationally on clr_valid; sources must not make valid depend on ready.
- Push: a handshake on either source writes {x,y,colour} into the FIFO tail at that clock edge. At most one push per cycle.
- Full: count==DEPTH makes both readys 0, even if a pop occurs the same cycle (no pass-through on full).
- Pop:
  - out_plot = count≠0; out_* shows the FIFO head, driven from registers.
  - Entry removed when out_plot AND out_ready.
  - Simultaneous push and pop with 0<count<DEPTH leaves count unchanged.
- Latency: a pixel accepted at edge N appears on out_* at N+1 at the earliest. Order is preserved exactly as accepted.
- Empty: out_plot=0; out_* hold their last values.
- Stall: while out_ready=0, the head is held stable; up to DEPTH pixels buffer, then the sources are backpressured.
- Tile stream during a clear pass: stalled, not dropped. It resumes the cycle after the clr_last handshake, if clr_valid is then low.
- Pointers wrap modulo DEPTH; count has log2(DEPTH)+1 bits.

Optional Feature:
- Macro: PLOT_ARBITER_CLIP_EN
- Defined:
  - An accepted pixel with x≥SCREEN_W or y≥SCREEN_H completes its handshake normally but is not pushed.
  - Extra output clip_seen (1 bit, reset 0) goes high and stays sticky until reset.
  - For a clipped clr pixel with clr_last=1, lock still clears.
- Undefined: all pixels are pushed unchanged; clip_seen is absent.

Decomposition:
- Package piano_pkg: X_W, Y_W, COLOUR_W, SCREEN_W, SCREEN_H, and the colour constants (COL_WHITE=3'b111, COL_BLACK=3'b000).
- Sub-module plot_fifo:
  - Synchronous FIFO, width X_W+Y_W+COLOUR_W, depth DEPTH, async active-low reset.
  - Ports: push, pop, full, empty, head.
  - Arbitration and lock stay in plot_arbiter.

Test Plan:
- Single tile pixel (10,20,3'b000), out_ready=1: til_ready=1 at cycle 0 → out_plot=1 with (10,20,0) at cycle 1 only; busy drops at cycle 2.
- Clear pass of 5 pixels (x=0..4, y=0, 3'b111, last on x=4) while til_valid is held high throughout: til_ready=0 until the cycle after the x=4 handshake. Output order is x=0..4, then the tile pixel.
- clr_valid deasserted for 3 cycles mid-pass (after 2 pixels): clear_active stays 1 and til_ready stays 0 during the gap.
- out_ready=0 with 6 tile pixels offered, DEPTH=4: 4 accepted, then til_ready=0. Release → pixels 1..6 emerge in order, one per cycle, with no gaps after the release.
- resetn pulsed low for 1 cycle mid-pass with 3 entries buffered: out_plot=0, clear_active=0, out_* =0 immediately. The next tile pixel is granted the cycle after release.
- PLOT_ARBITER_CLIP_EN defined: tile (320,5) and clr (0,240,last=1) are both handshaken, nothing is plotted, clip_seen=1 and lock=0.

Source files
------------

// File: rtl/piano_pkg.sv
// Shared widths, screen limits, colour constants and the pixel record
// used by the plot arbiter and its FIFO.
package piano_pkg;

    localparam int X_W      = 9;
    localparam int Y_W      = 8;
    localparam int COLOUR_W = 3;
    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;

    localparam logic [COLOUR_W-1:0] COL_WHITE = 3'b111;
    localparam logic [COLOUR_W-1:0] COL_BLACK = 3'b000;

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } lock_state_t;

    typedef struct packed {
        logic [X_W-1:0]      x;
        logic [Y_W-1:0]      y;
        logic [COLOUR_W-1:0] colour;
    } pixel_t;

    function automatic logic on_screen(pixel_t p);
        return (int'(p.x) < SCREEN_W) && (int'(p.y) < SCREEN_H);
    endfunction

endpackage

// File: rtl/plot_fifo.sv
// Small synchronous FIFO buffering accepted pixels ahead of the VGA adapter.
// Pointers wrap naturally because DEPTH is a power of two.
module plot_fifo #(
    parameter int W     = 20,
    parameter int DEPTH = 4
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/plot_arbiter.sv
// Merges the screen-clear and tile pixel streams into one plot stream; a
// started clear pass owns the bus until its last pixel. Optional clipping
// of off-screen pixels is enabled with PLOT_ARBITER_CLIP_EN.
//
// state     | meaning
// ST_IDLE   | no clear pass in progress; clr_valid alone still wins
// ST_LOCKED | clear pass started, tile stream held off until clr_last
module plot_arbiter
    import piano_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                clr_valid,
    output logic                clr_ready,
    input  logic                clr_last,
    input  logic [X_W-1:0]      clr_x,
    input  logic [Y_W-1:0]      clr_y,
    input  logic [COLOUR_W-1:0] clr_colour,
    input  logic                til_valid,
    output logic                til_ready,
    input  logic [X_W-1:0]      til_x,
    input  logic [Y_W-1:0]      til_y,
    input  logic [COLOUR_W-1:0] til_colour,
    output logic                out_plot,
    input  logic                out_ready,
    output logic [X_W-1:0]      out_x,
    output logic [Y_W-1:0]      out_y,
    output logic [COLOUR_W-1:0] out_colour,
    output logic                clear_active,
`ifdef PLOT_ARBITER_CLIP_EN
    output logic                clip_seen,
`endif
    output logic                busy
);

    lock_state_t state;
    lock_state_t state_nxt;
    logic        lock;
    logic        grant_clr;
    logic        clr_hs;
    logic        til_hs;
    logic        push;
    logic        pop;
    logic        full;
    logic        empty;
    pixel_t      in_pix;
    pixel_t      head_pix;
    pixel_t      last_pix;
    pixel_t      shown_pix;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (clr_hs) state_nxt = clr_last ? ST_IDLE : ST_LOCKED;
    end

    always_comb begin
        lock = (state == ST_LOCKED);
    end

    // No pass-through on full: readiness ignores a same-cycle pop.
    assign grant_clr = lock | clr_valid;
    assign clr_ready = grant_clr & ~full;
    assign til_ready = ~grant_clr & ~full;
    assign clr_hs    = clr_valid & clr_ready;
    assign til_hs    = til_valid & til_ready;

    assign in_pix = grant_clr ? pixel_t'{clr_x, clr_y, clr_colour}
                              : pixel_t'{til_x, til_y, til_colour};

`ifdef PLOT_ARBITER_CLIP_EN
    assign push = (clr_hs | til_hs) & on_screen(in_pix);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)                                      clip_seen <= 1'b0;
        else if ((clr_hs | til_hs) && !on_screen(in_pix)) clip_seen <= 1'b1;
    end
`else
    assign push = clr_hs | til_hs;
`endif

    assign out_plot = ~empty;
    assign pop      = out_plot & out_ready;

    plot_fifo #(
        .W     ($bits(pixel_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .resetn    (resetn),
        .push      (push),
        .pop       (pop),
        .push_data (in_pix),
        .full      (full),
        .empty     (empty),
        .head      (head_pix)
    );

    // Remember the pixel last handed over so the output holds it when empty.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)  last_pix <= '0;
        else if (pop) last_pix <= head_pix;
    end

    assign shown_pix    = empty ? last_pix : head_pix;
    assign out_x        = shown_pix.x;
    assign out_y        = shown_pix.y;
    assign out_colour   = shown_pix.colour;
    assign clear_active = grant_clr;
    assign busy         = grant_clr | ~empty;

endmodule
